bandai2003_cfg_sequencer: RTL and testbench

Host-side controller that brings a Bandai 2003 mapper out of reset and configures it.
- Pulses the mapper reset, then drives the two-address unlock sequence (5Ah, A5h).
- Captures and checks the 18-bit sync bitstream on SO.
- Programs the four bank registers (C0h–C3h), then serves run-time bank-register rewrites through a req/ack port.
- Sits between the dev-board host logic and the cartridge bus pins.

---
 rtl/bandai2003_pkg.sv | 41 ++++
 rtl/bandai2003_reg_access.sv | 118 +++++++++++
 rtl/bandai2003_cfg_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_bandai2003_cfg_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bandai2003_pkg.sv
// Shared constants and state types for the Bandai 2003 mapper configuration sequencer.
// Used by both the top-level sequencer and the register-access engine.
package bandai2003_pkg;

    localparam logic [7:0]  ADDR_UNLOCK_ACK = 8'h5A;
    localparam logic [7:0]  ADDR_UNLOCK_NAK = 8'hA5;
    localparam logic [7:0]  ADDR_LAO        = 8'hC0;
    localparam logic [7:0]  ADDR_BRAM       = 8'hC1;
    localparam logic [7:0]  ADDR_BROM0      = 8'hC2;
    localparam logic [7:0]  ADDR_BROM1      = 8'hC3;
    localparam logic [17:0] SYNC_WORD       = 18'h05140;

    localparam logic [1:0]  ERR_NONE        = 2'b00;
    localparam logic [1:0]  ERR_SYNC        = 2'b01;
    localparam logic [1:0]  ERR_READBACK    = 2'b10;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CART_RST   = 3'd1,
        UNLOCK_ACK = 3'd2,
        UNLOCK_NAK = 3'd3,
        CAPTURE    = 3'd4,
        CFG        = 3'd5,
        READY      = 3'd6,
        ERROR      = 3'd7
    } seq_state_t;

    typedef enum logic [2:0] {
        ENG_IDLE   = 3'd0,
        ENG_SETUP  = 3'd1,
        ENG_STROBE = 3'd2,
        ENG_HOLD   = 3'd3,
        ENG_READ   = 3'd4,
        ENG_TURN   = 3'd5
    } eng_state_t;

    function automatic logic [7:0] bank_addr(input logic [1:0] idx);
        return ADDR_LAO + {6'b000000, idx};
    endfunction

endpackage

// File: rtl/bandai2003_reg_access.sv
// Bank-register write engine: SETUP / STROBE / HOLD, plus READ + turnaround when
// CART_READBACK_VERIFY_EN is defined. done/mismatch are valid in the engine's last cycle.
module bandai2003_reg_access
    import bandai2003_pkg::*;
#(
    parameter int WR_PULSE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [1:0] idx,
    input  logic [7:0] data,
    input  logic [7:0] dq_i,
    output logic       done,
    output logic       mismatch,
    output logic [7:0] addr,
    output logic       ssn,
    output logic       cen,
    output logic       wen,
    output logic       oen,
    output logic [7:0] dq_o,
    output logic       dq_oe
);

`ifdef CART_READBACK_VERIFY_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif
    localparam int PW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

    eng_state_t    phase;
    logic [PW-1:0] pcnt;
    logic [7:0]    wdata;
    logic          mism_r;

    assign cen      = 1'b1;
    assign done     = READBACK ? (phase == ENG_TURN) : (phase == ENG_HOLD);
    assign mismatch = READBACK & mism_r;

    // Phase sequencing with registered bus strobes; the bus returns to idle after the last phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= ENG_IDLE;
            pcnt   <= '0;
            wdata  <= 8'h00;
            mism_r <= 1'b0;
            addr   <= 8'h00;
            ssn    <= 1'b1;
            wen    <= 1'b1;
            oen    <= 1'b1;
            dq_o   <= 8'h00;
            dq_oe  <= 1'b0;
        end else begin
            case (phase)
                ENG_IDLE: begin
                    if (go) begin
                        phase  <= ENG_SETUP;
                        addr   <= bank_addr(idx);
                        ssn    <= 1'b0;
                        dq_oe  <= 1'b1;
                        dq_o   <= data;
                        wdata  <= data;
                        mism_r <= 1'b0;
                    end
                end
                ENG_SETUP: begin
                    phase <= ENG_STROBE;
                    wen   <= 1'b0;
                    pcnt  <= '0;
                end
                ENG_STROBE: begin
                    if (pcnt == PW'(WR_PULSE - 1)) begin
                        phase <= ENG_HOLD;
                        wen   <= 1'b1;
                    end else begin
                        pcnt <= pcnt + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                ENG_HOLD: begin
                    if (READBACK) begin
                        // Keep address and select, release DQ and open the output enable.
                        phase <= ENG_READ;
                        oen   <= 1'b0;
                        dq_oe <= 1'b0;
                        dq_o  <= 8'h00;
                    end else begin
                        phase <= ENG_IDLE;
                        addr  <= 8'h00;
                        ssn   <= 1'b1;
                        dq_oe <= 1'b0;
                        dq_o  <= 8'h00;
                    end
                end
                ENG_READ: begin
                    phase  <= ENG_TURN;
                    mism_r <= (dq_i != wdata);
                    addr   <= 8'h00;
                    ssn    <= 1'b1;
                    oen    <= 1'b1;
                end
                ENG_TURN: begin
                    phase <= ENG_IDLE;
                end
                default: begin
                    phase <= ENG_IDLE;
                    addr  <= 8'h00;
                    ssn   <= 1'b1;
                    wen   <= 1'b1;
                    oen   <= 1'b1;
                    dq_o  <= 8'h00;
                    dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bandai2003_cfg_sequencer.sv
// Host-side bring-up sequencer for the Bandai 2003 mapper: reset, unlock, sync check,
// bank programming and run-time rewrites. Optional readback verify: CART_READBACK_VERIFY_EN.
module bandai2003_cfg_sequencer
    import bandai2003_pkg::*;
#(
    parameter int RST_HOLD     = 4,
    parameter int WR_PULSE     = 2,
    parameter int SYNC_RETRIES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cfg_lao,
    input  logic [7:0] cfg_bram,
    input  logic [7:0] cfg_brom0,
    input  logic [7:0] cfg_brom1,
    input  logic       bank_wr_req,
    input  logic [1:0] bank_wr_sel,
    input  logic [7:0] bank_wr_data,
    output logic       bank_wr_ack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic       cart_rstn,
    output logic [7:0] cart_addr,
    output logic       cart_ssn,
    output logic       cart_cen,
    output logic       cart_wen,
    output logic       cart_oen,
    output logic [7:0] cart_dq_o,
    output logic       cart_dq_oe,
    input  logic [7:0] cart_dq_i,
    input  logic       cart_so
);

    localparam int RW      = (SYNC_RETRIES > 0) ? $clog2(SYNC_RETRIES + 1) : 1;
    localparam int CNT_MAX = (RST_HOLD > 18) ? RST_HOLD : 18;
    localparam int CW      = $clog2(CNT_MAX);

    seq_state_t    state;
    logic [RW-1:0] retry;
    logic [17:0]   cap;
    logic [CW-1:0] cnt;
    logic [1:0]    cfg_idx;
    logic          wr_active;
    logic          go;
    logic [1:0]    go_idx;
    logic [7:0]    go_data;
    logic [7:0]    top_addr;
    logic          eng_done;
    logic          eng_mismatch;
    logic [7:0]    eng_addr;
    logic [17:0]   cap_next;
    logic [1:0]    cfg_next;

    function automatic logic [7:0] cfg_value(input logic [1:0] i);
        case (i)
            2'd0:    return cfg_lao;
            2'd1:    return cfg_bram;
            2'd2:    return cfg_brom0;
            default: return cfg_brom1;
        endcase
    endfunction

    assign cap_next = {cart_so, cap[17:1]};
    assign cfg_next = cfg_idx + 2'd1;
    // The engine and the unlock phases never drive the address at the same time; idle is 00h.
    assign cart_addr = top_addr | eng_addr;

    bandai2003_reg_access #(.WR_PULSE(WR_PULSE)) u_reg_access (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .idx      (go_idx),
        .data     (go_data),
        .dq_i     (cart_dq_i),
        .done     (eng_done),
        .mismatch (eng_mismatch),
        .addr     (eng_addr),
        .ssn      (cart_ssn),
        .cen      (cart_cen),
        .wen      (cart_wen),
        .oen      (cart_oen),
        .dq_o     (cart_dq_o),
        .dq_oe    (cart_dq_oe)
    );

    // Main sequencer: state, counters and all registered status/bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            retry       <= '0;
            cap         <= 18'h00000;
            cnt         <= '0;
            cfg_idx     <= 2'd0;
            wr_active   <= 1'b0;
            go          <= 1'b0;
            go_idx      <= 2'd0;
            go_data     <= 8'h00;
            top_addr    <= 8'h00;
            cart_rstn   <= 1'b0;
            bank_wr_ack <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            go          <= 1'b0;
            bank_wr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CART_RST;
                        retry <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CART_RST: begin
                    if (cnt == CW'(RST_HOLD - 1)) begin
                        state     <= UNLOCK_ACK;
                        cart_rstn <= 1'b1;
                        top_addr  <= ADDR_UNLOCK_ACK;
                    end else begin
                        cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                UNLOCK_ACK: begin
                    state    <= UNLOCK_NAK;
                    top_addr <= ADDR_UNLOCK_NAK;
                end
                UNLOCK_NAK: begin
                    // First SO sample is taken on the edge that leaves the A5h cycle.
                    state    <= CAPTURE;
                    top_addr <= 8'h00;
                    cap      <= cap_next;
                    cnt      <= CW'(1);
                end
                CAPTURE: begin
                    cap <= cap_next;
                    if (cnt == CW'(17)) begin
                        if (cap_next == SYNC_WORD) begin
                            state   <= CFG;
                            cfg_idx <= 2'd0;
                            go      <= 1'b1;
                            go_idx  <= 2'd0;
                            go_data <= cfg_lao;
                        end else if (retry < RW'(SYNC_RETRIES)) begin
                            state     <= CART_RST;
                            retry     <= retry + {{(RW-1){1'b0}}, 1'b1};
                            cnt       <= '0;
                            cart_rstn <= 1'b0;
                        end else begin
                            state    <= ERROR;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_SYNC;
                        end
                    end else begin
                        cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                CFG: begin
                    if (eng_done) begin
                        if (eng_mismatch) begin
                            state    <= ERROR;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_READBACK;
                        end else if (cfg_idx == 2'd3) begin
                            state <= READY;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cfg_idx <= cfg_next;
                            go      <= 1'b1;
                            go_idx  <= cfg_next;
                            go_data <= cfg_value(cfg_next);
                        end
                    end
                end
                READY: begin
                    if (wr_active) begin
                        if (eng_done) begin
                            wr_active <= 1'b0;
                            if (eng_mismatch) begin
                                state    <= ERROR;
                                done     <= 1'b0;
                                error    <= 1'b1;
                                err_code <= ERR_READBACK;
                            end else begin
                                bank_wr_ack <= 1'b1;
                            end
                        end
                    end else if (start) begin
                        state     <= CART_RST;
                        retry     <= '0;
                        cnt       <= '0;
                        cart_rstn <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end else if (bank_wr_req) begin
                        wr_active <= 1'b1;
                        go        <= 1'b1;
                        go_idx    <= bank_wr_sel;
                        go_data   <= bank_wr_data;
                    end
                end
                ERROR: begin
                    if (start) begin
                        state     <= CART_RST;
                        retry     <= '0;
                        cnt       <= '0;
                        cart_rstn <= 1'b0;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        err_code  <= ERR_NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bandai2003_cfg_sequencer.sv
// Self-checking bench: expected bus/status timeline built from the protocol rules,
// compared every cycle, plus a mapper model (SO sync source, bank registers, readback).
module tb_bandai2003_cfg_sequencer;

    localparam int RST_HOLD     = 4;
    localparam int WR_PULSE     = 2;
    localparam int SYNC_RETRIES = 2;
`ifdef CART_READBACK_VERIFY_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cfg_lao, cfg_bram, cfg_brom0, cfg_brom1;
    logic       bank_wr_req;
    logic [1:0] bank_wr_sel;
    logic [7:0] bank_wr_data;
    logic       bank_wr_ack, busy, done, error;
    logic [1:0] err_code;
    logic       cart_rstn, cart_ssn, cart_cen, cart_wen, cart_oen, cart_dq_oe;
    logic [7:0] cart_addr, cart_dq_o, cart_dq_i;
    logic       cart_so = 1'b0;

    typedef struct packed {
        logic       rstn;
        logic [7:0] addr;
        logic       ssn;
        logic       cen;
        logic       wen;
        logic       oen;
        logic [7:0] dq_o;
        logic       dq_oe;
        logic       busy;
        logic       done;
        logic       error;
        logic [1:0] err;
        logic       ack;
    } bus_t;

    bus_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         wen_lows = 0;
    logic [7:0] br[4];
    logic       so_stuck   = 1'b0;
    logic       corrupt_c3 = 1'b0;
    logic [17:0] sync_word = 18'h05140;
    int         so_idx = 18;

    bandai2003_cfg_sequencer #(
        .RST_HOLD(RST_HOLD), .WR_PULSE(WR_PULSE), .SYNC_RETRIES(SYNC_RETRIES)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_lao(cfg_lao), .cfg_bram(cfg_bram), .cfg_brom0(cfg_brom0), .cfg_brom1(cfg_brom1),
        .bank_wr_req(bank_wr_req), .bank_wr_sel(bank_wr_sel), .bank_wr_data(bank_wr_data),
        .bank_wr_ack(bank_wr_ack), .busy(busy), .done(done), .error(error), .err_code(err_code),
        .cart_rstn(cart_rstn), .cart_addr(cart_addr), .cart_ssn(cart_ssn), .cart_cen(cart_cen),
        .cart_wen(cart_wen), .cart_oen(cart_oen), .cart_dq_o(cart_dq_o), .cart_dq_oe(cart_dq_oe),
        .cart_dq_i(cart_dq_i), .cart_so(cart_so)
    );

    always #5 clk = ~clk;

    // Mapper bank registers latch DQ while selected with WEn low.
    always @(posedge clk) begin
        if (!cart_ssn && !cart_wen && cart_addr[7:2] == 6'b110000)
            br[cart_addr[1:0]] <= cart_dq_o;
    end

    assign cart_dq_i = (corrupt_c3 && cart_addr == 8'hC3) ? 8'hFF : br[cart_addr[1:0]];

    // Mapper SO: once A5h is seen, shift out the 18-bit sync word LSB first.
    always @(negedge clk) begin
        if (so_stuck) begin
            cart_so <= 1'b1;
        end else if (cart_addr == 8'hA5) begin
            cart_so <= sync_word[0];
            so_idx  <= 1;
        end else if (so_idx < 18) begin
            cart_so <= sync_word[so_idx];
            so_idx  <= so_idx + 1;
        end else begin
            cart_so <= 1'b0;
        end
    end

    function automatic bus_t idle_vec(input logic rstn, input logic bsy, input logic dn,
                                      input logic er, input logic [1:0] ec, input logic ak);
        bus_t v;
        v = '{rstn: rstn, addr: 8'h00, ssn: 1'b1, cen: 1'b1, wen: 1'b1, oen: 1'b1,
              dq_o: 8'h00, dq_oe: 1'b0, busy: bsy, done: dn, error: er, err: ec, ack: ak};
        return v;
    endfunction

    task automatic push_n(input bus_t v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // One register access: gap cycle, SETUP, WR_PULSE strobe cycles, HOLD, then optional READ + turnaround.
    task automatic push_write(input logic [7:0] a, input logic [7:0] d, input logic bsy, input logic dn);
        bus_t g, v;
        g = idle_vec(1'b1, bsy, dn, 1'b0, 2'b00, 1'b0);
        exp_q.push_back(g);
        v = g; v.addr = a; v.ssn = 1'b0; v.dq_oe = 1'b1; v.dq_o = d;
        exp_q.push_back(v);
        v.wen = 1'b0;
        push_n(v, WR_PULSE);
        v.wen = 1'b1;
        exp_q.push_back(v);
        if (RB) begin
            v = g; v.addr = a; v.ssn = 1'b0; v.oen = 1'b0;
            exp_q.push_back(v);
            exp_q.push_back(g);
        end
    endtask

    task automatic push_attempt();
        bus_t v;
        push_n(idle_vec(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), RST_HOLD);
        v = idle_vec(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        v.addr = 8'h5A; exp_q.push_back(v);
        v.addr = 8'hA5; exp_q.push_back(v);
        push_n(idle_vec(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), 17);
    endtask

    task automatic push_full(input logic [7:0] c0, c1, c2, c3);
        push_attempt();
        push_write(8'hC0, c0, 1'b1, 1'b0);
        push_write(8'hC1, c1, 1'b1, 1'b0);
        push_write(8'hC2, c2, 1'b1, 1'b0);
        push_write(8'hC3, c3, 1'b1, 1'b0);
        push_n(idle_vec(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0), 2);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < max_cycles) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout with %0d expected cycles left, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; bank_wr_req = 1'b0; bank_wr_sel = 2'd0; bank_wr_data = 8'h00;
        cfg_lao = 8'h00; cfg_bram = 8'h01; cfg_brom0 = 8'h02; cfg_brom1 = 8'h03;

        // Per-cycle comparison of the DUT against the expected timeline.
        fork
            forever begin
                bus_t e, act;
                @(posedge clk);
                #1;
                if (cart_wen === 1'b0) wen_lows++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    act = {cart_rstn, cart_addr, cart_ssn, cart_cen, cart_wen, cart_oen, cart_dq_o,
                           cart_dq_oe, busy, done, error, err_code, bank_wr_ack};
                    n_checks++;
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL trace @%0t: actual %h required %h", $time, act, e);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_rstn", {31'd0, cart_rstn}, 32'd0);
        check("reset_addr", {24'd0, cart_addr}, 32'h00);
        check("reset_wen", {31'd0, cart_wen}, 32'd1);
        check("reset_dq_oe", {31'd0, cart_dq_oe}, 32'd0);
        check("reset_busy_done_err", {29'd0, busy, done, error}, 32'd0);
        check("reset_err_code", {30'd0, err_code}, 32'd0);
        rst = 1'b0;

        // Full bring-up with 00h..03h.
        @(negedge clk); start = 1'b1; push_full(8'h00, 8'h01, 8'h02, 8'h03);
        @(negedge clk); start = 1'b0;
        wait_drain(300, "bringup");
        check("bringup_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 4; i++) check("bringup_br", {24'd0, br[i]}, i);

        // Run-time rewrite of C2h.
        wen_lows = 0;
        bank_wr_req = 1'b1; bank_wr_sel = 2'd2; bank_wr_data = 8'h5C;
        push_write(8'hC2, 8'h5C, 1'b0, 1'b1);
        exp_q.push_back(idle_vec(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1));
        exp_q.push_back(idle_vec(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0));
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bank_wr_ack) begin found = 1'b1; break; end
        end
        bank_wr_req = 1'b0;
        check("rt_ack_seen", {31'd0, found}, 32'd1);
        wait_drain(50, "rt_write");
        check("rt_br2", {24'd0, br[2]}, 32'h5C);
        check("rt_wen_low_cycles", wen_lows, WR_PULSE);

        // start and req together in READY: resequence, no ack.
        cfg_lao = 8'hA1; cfg_bram = 8'hB2; cfg_brom0 = 8'hC3; cfg_brom1 = 8'hD4;
        start = 1'b1; bank_wr_req = 1'b1; bank_wr_sel = 2'd1; bank_wr_data = 8'h77;
        push_full(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        @(negedge clk); start = 1'b0; bank_wr_req = 1'b0;
        wait_drain(300, "start_vs_req");
        check("start_vs_req_br1", {24'd0, br[1]}, 32'hB2);

        // RST during the C1h strobe, then a clean rerun.
        start = 1'b1; push_full(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cart_addr == 8'hC1 && cart_wen == 1'b0) begin found = 1'b1; break; end
        end
        check("c1_strobe_seen", {31'd0, found}, 32'd1);
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("midrst_rstn_wen_ssn", {29'd0, cart_rstn, cart_wen, cart_ssn}, 32'd3);
        check("midrst_addr", {24'd0, cart_addr}, 32'h00);
        check("midrst_dq_oe_busy", {30'd0, cart_dq_oe, busy}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start = 1'b1; push_full(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        @(negedge clk); start = 1'b0;
        wait_drain(300, "after_rst");
        check("after_rst_br3", {24'd0, br[3]}, 32'hD4);

        // SO stuck high: three attempts, then sync error, no writes.
        so_stuck = 1'b1; wen_lows = 0;
        start = 1'b1;
        for (int a = 0; a <= SYNC_RETRIES; a++) push_attempt();
        push_n(idle_vec(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0), 3);
        @(negedge clk); start = 1'b0;
        wait_drain(300, "sync_fail");
        check("sync_fail_err_code", {30'd0, err_code}, 32'd1);
        check("sync_fail_error_done", {30'd0, error, done}, 32'd2);
        check("sync_fail_no_wen", wen_lows, 0);

        // Recovery from ERROR.
        so_stuck = 1'b0;
        start = 1'b1; push_full(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        @(negedge clk); start = 1'b0;
        wait_drain(300, "recover");
        check("recover_err_code", {30'd0, err_code}, 32'd0);

`ifdef CART_READBACK_VERIFY_EN
        // Corrupted C3h readback.
        corrupt_c3 = 1'b1;
        start = 1'b1;
        push_attempt();
        push_write(8'hC0, 8'hA1, 1'b1, 1'b0);
        push_write(8'hC1, 8'hB2, 1'b1, 1'b0);
        push_write(8'hC2, 8'hC3, 1'b1, 1'b0);
        push_write(8'hC3, 8'hD4, 1'b1, 1'b0);
        push_n(idle_vec(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0), 2);
        @(negedge clk); start = 1'b0;
        wait_drain(300, "readback");
        check("readback_err_code", {30'd0, err_code}, 32'd2);
        check("readback_error_done", {30'd0, error, done}, 32'd2);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
